hi_lo_unit: RTL
===============

# hi_lo_unit

Architectural HI/LO register pair for the MIPS datapath. It sits downstream of the 32-bit ALU and captures the 64-bit multiply result, carried as the ALU's HiResult/ALUResult pair. It serves mthi/mtlo writes and mfhi/mflo reads, and executes madd/msub as a two-stage accumulate pipeline. It raises a one-cycle stall when a read would observe an unfinished accumulate.

## Interface
Parameters:
- WIDTH, 32, width of each of HI and LO; the accumulate datapath is 2*WIDTH.

Ports:
- Clk  in  1  rising-edge clock; all state changes on this edge.
- Reset  in  1  synchronous, active-high; sampled on Clk rising edge.
- HiLoOp  in  3  operation code:
  - 000 none
  - 001 write {ProductHi, ProductLo}
  - 010 mthi
  - 011 mtlo
  - 100 madd
  - 101 maddu
  - 110 msub
  - 111 msubu
- ProductHi  in  WIDTH  upper half of the ALU result; mult/multu high word.
- ProductLo  in  WIDTH  lower half of the ALU result; also the mthi/mtlo source value.
- ReadSel  in  2  read selector: 00 none, 01 mfhi, 10 mflo, 11 none.
- ReadData  out  WIDTH  combinational read result; 0 when ReadSel is none.
- Stall  out  1  read must be held and retried next cycle.
- Hi  out  WIDTH  architectural HI register.
- Lo  out  WIDTH  architectural LO register.

## Operation
Write operations:
- 001: {Hi,Lo} <= {ProductHi,ProductLo} at the end of the issue cycle.
- 010: Hi <= ProductLo. 011: Lo <= ProductLo. The other register is unchanged.

Accumulate operations (100–111):
- Stage 1, issue cycle N: AccProd <= {ProductHi,ProductLo}, AccSub <= HiLoOp[1], AccPending <= 1.
- Stage 2, cycle N+1: {Hi,Lo} <= {Hi,Lo} + AccProd, or minus AccProd if AccSub. This is modular 2*WIDTH arithmetic with no carry-out or overflow flag. AccPending clears unless a new accumulate issues in the same cycle.
- maddu/msubu behave identically to madd/msub. Signedness is resolved upstream by the ALU's signed/unsigned multiply.

Overlap rules:
- Back-to-back accumulates, issued at N and N+1: the second uses {Hi,Lo} as updated by the first. Sustained throughput is one accumulate per cycle.
- Write op issued in the cycle stage 2 completes: the newer op wins per half.
  - 001 overwrites both halves; the accumulate result is discarded.
  - 010 takes Hi from ProductLo and Lo from the accumulate sum.
  - 011 takes Lo from ProductLo and Hi from the accumulate sum.

Reads:
- ReadData = Hi for 01, Lo for 10, taken from the current registers.
- Forwarding is governed by the configuration macro (see Configuration).
- A same-cycle write op never forwards into a read. Reads see the pre-edge value.

Reset:
- Clears Hi, Lo, AccProd, AccSub and AccPending.
- Discards any in-flight accumulate.
- HiLoOp in the reset cycle is ignored.

## Timing
- Reset values: Hi=0, Lo=0, ReadData=0, Stall=0.
- Write latency: 1 edge; visible on Hi/Lo the cycle after issue.
- Accumulate latency: 2 edges; visible on Hi/Lo at cycle N+2.
- Stall is combinational from ReadSel and AccPending. It lasts at most one cycle per accumulate, or more if accumulates issue back-to-back.
- HiLoOp is accepted every cycle regardless of Stall. Upstream must hold ReadSel while Stall=1.

## Configuration
- HILO_FORWARD_EN defined: a read while AccPending=1 returns the stage-2 sum half combinationally, and Stall stays 0.
- HILO_FORWARD_EN undefined: a read while AccPending=1 asserts Stall=1 and returns ReadData=0. The read is satisfied from the registers next cycle.

## Test plan
1. Reset, then 001 with ProductHi=0x00000001, ProductLo=0xFFFFFFFE → next cycle Hi=0x00000001, Lo=0xFFFFFFFE.
2. Hi:Lo=0x0:0xFFFFFFFF, madd with product 0x0:0x00000001 → two cycles later Hi=0x00000001, Lo=0x00000000 (carry across halves).
3. Hi:Lo=0x0:0x0, msub with product 0x0:0x1 → Hi=0xFFFFFFFF, Lo=0xFFFFFFFF (wrap-around).
4. madd issued, mflo in the following cycle:
   - forward build: ReadData equals the sum's low half, Stall=0;
   - non-forward build: Stall=1 and ReadData=0, then the correct value with Stall=0 one cycle later.
5. madd at N, then mthi with ProductLo=0xABCD0000 at N+1 → Hi=0xABCD0000, Lo equals the accumulated low half.
6. madd at N, Reset at N+1 → Hi=Lo=0, AccPending=0, Stall=0 at N+2.

Source files
------------

// File: rtl/hi_lo_unit.sv
// hi_lo_unit: MIPS HI/LO register pair with mthi/mtlo/mult writes, mfhi/mflo reads
// and a two-stage madd/msub accumulate pipeline.
// Ports:
//   Clk, Reset            rising-edge clock, synchronous active-high reset
//   HiLoOp[2:0]           000 none, 001 write product, 010 mthi, 011 mtlo, 1xx accumulate (x1x = subtract)
//   ProductHi/ProductLo   64-bit product halves; ProductLo is also the mthi/mtlo source
//   ReadSel[1:0]          01 mfhi, 10 mflo, else no read
//   ReadData              combinational read result, 0 when no read or stalled
//   Stall                 read hits an unfinished accumulate; retry next cycle
//   Hi, Lo                architectural registers
// Config macro: HILO_FORWARD_EN forwards the pending accumulate sum into reads instead of stalling.
module hi_lo_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [2:0]       HiLoOp,
    input  logic [WIDTH-1:0] ProductHi,
    input  logic [WIDTH-1:0] ProductLo,
    input  logic [1:0]       ReadSel,
    output logic [WIDTH-1:0] ReadData,
    output logic             Stall,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);
    logic [WIDTH-1:0]   r_hi, r_lo;
    logic [2*WIDTH-1:0] r_acc_prod;
    logic               r_acc_sub, r_acc_pend;
    logic [2*WIDTH-1:0] w_sum, w_cur, w_next, w_src;
    logic               w_rd;

    // Stage-2 result; when nothing is pending the registers carry through unchanged.
    assign w_sum = r_acc_sub ? {r_hi, r_lo} - r_acc_prod : {r_hi, r_lo} + r_acc_prod;
    assign w_cur = r_acc_pend ? w_sum : {r_hi, r_lo};

    // A write op landing on the completing accumulate overrides only the halves it names.
    always_comb begin
        w_next = w_cur;
        if (HiLoOp == 3'b001) w_next = {ProductHi, ProductLo};
        else if (HiLoOp == 3'b010) w_next = {ProductLo, w_cur[WIDTH-1:0]};
        else if (HiLoOp == 3'b011) w_next = {w_cur[2*WIDTH-1:WIDTH], ProductLo};
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_hi       <= '0;
            r_lo       <= '0;
            r_acc_prod <= '0;
            r_acc_sub  <= 1'b0;
            r_acc_pend <= 1'b0;
        end else begin
            {r_hi, r_lo} <= w_next;
            r_acc_pend   <= HiLoOp[2];
            if (HiLoOp[2]) begin
                r_acc_prod <= {ProductHi, ProductLo};
                r_acc_sub  <= HiLoOp[1];
            end
        end
    end

    assign w_rd = (ReadSel == 2'b01) || (ReadSel == 2'b10);

`ifdef HILO_FORWARD_EN
    assign w_src = w_cur;
    assign Stall = 1'b0;
`else
    assign w_src = {r_hi, r_lo};
    assign Stall = w_rd && r_acc_pend;
`endif

    assign ReadData = (!w_rd || Stall) ? '0 :
                      (ReadSel == 2'b01) ? w_src[2*WIDTH-1:WIDTH] : w_src[WIDTH-1:0];
    assign Hi = r_hi;
    assign Lo = r_lo;
endmodule
